// File: rtl/link_slave_fsm_if.sv
// Byte link bundle between the burst master, the link slave and the downstream consumer.
// master: upstream/consumer side; slave: the link_slave_fsm side.
interface link_slave_fsm_if #(
  parameter int IDX_W = 2
);
  logic             req;
  logic [7:0]       data_in;
  logic             ack;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;
  logic             burst_done;
  logic [IDX_W-1:0] byte_idx;
  logic             seq_err;

  modport master (
    output req, data_in, out_ready,
    input  ack, out_valid, out_data, burst_done, byte_idx, seq_err
  );

  modport slave (
    input  req, data_in, out_ready,
    output ack, out_valid, out_data, burst_done, byte_idx, seq_err
  );
endinterface

// File: rtl/link_slave_fsm.sv
// Receiving end of the 4-phase req/ack byte link with a small receive FIFO and burst counting.
// Optional sequence checker enabled by defining LINK_SLAVE_SEQ_CHECK_EN.
module link_slave_fsm #(
  parameter int BURST_BYTES = 4,
  parameter int IDX_W       = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int PTR_W       = 2
) (
  input logic            clk,
  input logic            rst,
  link_slave_fsm_if.slave lnk
);

  localparam int               DATA_W   = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_BYTES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S0_WAITREQ = 2'b00,
    S1_ACKHIGH = 2'b01
  } state_e;

  state_e           state_q;
  logic             ack_q;
  logic             burst_done_q;
  logic [IDX_W-1:0] byte_idx_q;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  logic full, empty, push, pop;

`ifdef LINK_SLAVE_SEQ_CHECK_EN
  logic seq_err_q;

  function automatic logic [DATA_W-1:0] seq_expect(input logic [IDX_W-1:0] idx);
    return 8'hA0 + DATA_W'(idx);
  endfunction
`endif

  // Full uses the pre-pop count: a same-cycle pop never enables an accept.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = (state_q == S0_WAITREQ) && lnk.req && !full;
  assign pop   = lnk.out_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the cleared count keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= lnk.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S0_WAITREQ;
      ack_q        <= 1'b0;
      burst_done_q <= 1'b0;
      byte_idx_q   <= '0;
`ifdef LINK_SLAVE_SEQ_CHECK_EN
      seq_err_q    <= 1'b0;
`endif
    end else begin
      burst_done_q <= 1'b0;
      case (state_q)
        S0_WAITREQ: begin
          if (push) begin
            ack_q   <= 1'b1;
            state_q <= S1_ACKHIGH;
`ifdef LINK_SLAVE_SEQ_CHECK_EN
            if (lnk.data_in != seq_expect(byte_idx_q)) seq_err_q <= 1'b1;
`endif
          end
        end
        S1_ACKHIGH: begin
          if (!lnk.req) begin
            ack_q   <= 1'b0;
            state_q <= S0_WAITREQ;
            if (byte_idx_q == LAST_IDX) begin
              byte_idx_q   <= '0;
              burst_done_q <= 1'b1;
            end else begin
              byte_idx_q <= byte_idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q <= S0_WAITREQ;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign lnk.ack        = ack_q;
  assign lnk.burst_done = burst_done_q;
  assign lnk.byte_idx   = byte_idx_q;
  assign lnk.out_valid  = !empty;
  assign lnk.out_data   = mem_q[rd_ptr_q];
`ifdef LINK_SLAVE_SEQ_CHECK_EN
  assign lnk.seq_err    = seq_err_q;
`else
  assign lnk.seq_err    = 1'b0;
`endif

endmodule

// File: tb/tb_link_slave_fsm.sv
// Directed bench for link_slave_fsm: master handshake driver, byte scoreboard, burst and seq_err models.
module tb_link_slave_fsm;

  logic clk = 1'b0;
  logic rst;

  link_slave_fsm_if #(.IDX_W(2)) lnk ();

  link_slave_fsm #(
    .BURST_BYTES(4),
    .IDX_W      (2),
    .FIFO_DEPTH (4),
    .PTR_W      (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lnk(lnk)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int bd_cnt = 0;
  int pop_cnt = 0;

  logic [7:0] sb[$];
  logic [1:0] exp_idx = 2'd0;
  logic       exp_seq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Consumer side: every pop is compared against the oldest expected byte.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (lnk.burst_done === 1'b1) bd_cnt++;
      if (lnk.out_valid === 1'b1 && lnk.out_ready === 1'b1) begin
        pop_cnt++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("out_data", 32'(lnk.out_data), 32'(sb.pop_front()));
      end
    end
  end

  // All drive tasks start and end at #1 after a rising edge.
  task automatic start_byte(input logic [7:0] b);
    chk("byte_idx_at_req", 32'(lnk.byte_idx), 32'(exp_idx));
    lnk.req     = 1'b1;
    lnk.data_in = b;
    sb.push_back(b);
`ifdef LINK_SLAVE_SEQ_CHECK_EN
    if (b != (8'hA0 + {6'd0, exp_idx})) exp_seq = 1'b1;
`endif
  endtask

  task automatic wait_ack;
    int n = 0;
    while (lnk.ack !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_rise", 32'(lnk.ack), 32'd1);
    chk("seq_err", 32'(lnk.seq_err), 32'(exp_seq));
  endtask

  task automatic release_byte;
    logic exp_bd;
    lnk.req = 1'b0;
    @(posedge clk); #1;
    exp_bd  = (exp_idx == 2'd3);
    exp_idx = exp_idx + 2'd1;
    chk("ack_fall", 32'(lnk.ack), 32'd0);
    chk("burst_done", 32'(lnk.burst_done), 32'(exp_bd));
    chk("byte_idx_after", 32'(lnk.byte_idx), 32'(exp_idx));
  endtask

  task automatic send_byte(input logic [7:0] b);
    start_byte(b);
    wait_ack();
    release_byte();
  endtask

  task automatic drain(input int cycles);
    lnk.out_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    lnk.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bd0, p0;
    rst = 1'b1;
    lnk.req = 1'b0;
    lnk.data_in = 8'h00;
    lnk.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(lnk.ack), 32'd0);
    chk("rst_out_valid", 32'(lnk.out_valid), 32'd0);
    chk("rst_byte_idx", 32'(lnk.byte_idx), 32'd0);
    chk("rst_burst_done", 32'(lnk.burst_done), 32'd0);
    chk("rst_seq_err", 32'(lnk.seq_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single burst with consumer always ready
    bd0 = bd_cnt;
    lnk.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
    repeat (2) @(posedge clk);
    #1;
    chk("t1_bursts", 32'(bd_cnt - bd0), 32'd1);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    chk("t1_seq_err", 32'(lnk.seq_err), 32'(exp_seq));

    // 2: back-pressure with a full FIFO
    lnk.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    start_byte(8'h14);
    repeat (4) @(posedge clk);
    #1;
    chk("t2_stall_ack", 32'(lnk.ack), 32'd0);
    chk("t2_full_valid", 32'(lnk.out_valid), 32'd1);
    lnk.out_ready = 1'b1;
    @(posedge clk); #1;
    lnk.out_ready = 1'b0;
    chk("t2_ack_not_on_pop", 32'(lnk.ack), 32'd0);
    @(posedge clk); #1;
    chk("t2_ack_after_pop", 32'(lnk.ack), 32'd1);
    wait_ack();
    release_byte();
    drain(8);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    chk("t2_drained", 32'(lnk.out_valid), 32'd0);

    // 3: push and pop on the same edge with two entries held, across pointer wrap
    send_byte(8'h20);
    send_byte(8'h21);
    for (int i = 0; i < 6; i++) begin
      start_byte(8'h30 + 8'(i));
      lnk.out_ready = 1'b1;
      @(posedge clk); #1;
      lnk.out_ready = 1'b0;
      wait_ack();
      release_byte();
    end
    chk("t3_valid", 32'(lnk.out_valid), 32'd1);
    p0 = pop_cnt;
    drain(6);
    chk("t3_residual_count", 32'(pop_cnt - p0), 32'd2);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: reset while ack is high with three bytes buffered
    send_byte(8'h40);
    send_byte(8'h41);
    start_byte(8'h42);
    wait_ack();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t4_ack", 32'(lnk.ack), 32'd0);
    chk("t4_out_valid", 32'(lnk.out_valid), 32'd0);
    chk("t4_byte_idx", 32'(lnk.byte_idx), 32'd0);
    chk("t4_burst_done", 32'(lnk.burst_done), 32'd0);
    chk("t4_seq_err", 32'(lnk.seq_err), 32'd0);
    sb.delete();
    lnk.req = 1'b0;
    rst = 1'b0;
    exp_idx = 2'd0;
    exp_seq = 1'b0;
    lnk.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));

    // 5: sequence error on the third byte
    send_byte(8'hA0);
    send_byte(8'hA1);
    send_byte(8'h55);
    send_byte(8'hA3);
    repeat (3) @(posedge clk);
    #1;
`ifdef LINK_SLAVE_SEQ_CHECK_EN
    chk("t5_seq_err_sticky", 32'(lnk.seq_err), 32'd1);
`else
    chk("t5_seq_err_off", 32'(lnk.seq_err), 32'd0);
`endif
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: two bursts back to back
    bd0 = bd_cnt;
    for (int i = 0; i < 8; i++) send_byte(8'hB0 + 8'(i));
    repeat (3) @(posedge clk);
    #1;
    chk("t6_bursts", 32'(bd_cnt - bd0), 32'd2);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
    chk("t6_byte_idx", 32'(lnk.byte_idx), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
